prod_accumulator: RTL and testbench
===================================

Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 array multiplier (`multi_8bit`).
- Consumes a stream of 16-bit products over a valid/ready handshake.
- Sums a programmed number of products into a wide saturating accumulator.
- Presents the final sum over a second valid/ready handshake; forms the accumulate half of a dot-product / MAC datapath.

Parameters:
- PW, 16: product input width; matches the multiplier output P.
- AW, 24: accumulator width; must satisfy AW > PW.
- CW, 8: width of the product-count field len; maximum run length is 2^CW-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a new accumulation run; sampled only in IDLE.
- len  input  CW  number of products in the run; sampled together with start.
- in_valid  input  1  prod is valid.
- in_ready  output  1  block accepts prod this cycle.
- prod  input  PW  unsigned product from the multiplier.
- out_valid  output  1  acc_out holds the final result.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  AW  accumulator value; meaningful only while out_valid=1.
- ovf  output  1  sticky saturation flag for the current or last run.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, acc=0, remaining=0, ovf=0.
  - in_ready=0, out_valid=0, busy=0.
  - Takes priority over all other inputs.
  - Reset mid-run abandons the run; no result is produced.
- Outputs decode from registered state only (no input-to-output combinational paths):
  - in_ready = (state==ACCUM)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
  - acc_out = acc
- IDLE:
  - start=1 with len!=0: acc<=0, ovf<=0, remaining<=len, go to ACCUM.
  - start=1 with len==0: acc<=0, ovf<=0, go directly to DONE; result 0 is valid the next cycle.
  - start=0: stay in IDLE.
- ACCUM:
  - A transfer occurs on a clock edge with in_valid=1 and in_ready=1.
  - On transfer: sum = {1'b0,acc} + zero-extended prod, computed at AW+1 bits.
    - If sum[AW]=1 or ovf is already set: acc<=all ones, ovf<=1.
    - Otherwise: acc<=sum[AW-1:0].
    - remaining<=remaining-1.
  - A transfer with remaining==1 moves to DONE.
  - in_valid=0 (bubble): no change to any state.
  - start is ignored in this state.
- DONE:
  - acc and ovf hold.
  - out_ready=1: go to IDLE; out_valid is low from the next cycle.
  - out_ready=0: hold indefinitely, values stable.
  - start is ignored; a new start is accepted only on or after the first IDLE cycle.
- Latency:
  - out_valid rises on the edge of the last accepted product, i.e. it is high in the cycle after the final transfer.
  - Minimum run of N products takes N+1 cycles from the start edge to the first out_valid cycle.
- Arithmetic:
  - Unsigned only.
  - Saturation clamps at 2^AW-1 and never wraps.
- ovf clears only on an accepted start or on rst.

Test Plan:
1. Basic run: start, len=3, prods 0x0001, 0x00FF, 0xFFFF back-to-back.
   -> out_valid in the cycle after the 3rd transfer; acc_out=0x0100FF, ovf=0.
2. Backpressure and bubbles: len=4, prods 5, 6, 7, 8 with in_valid low on alternate cycles; out_ready held low 5 cycles.
   -> acc_out=26 (0x00001A) stable throughout; out_valid drops the cycle after out_ready=1.
3. Saturation, instance with AW=20: len=17, all prods 0xFFFF.
   -> acc_out=0xFFFFF, ovf=1.
   Same instance, len=16, all prods 0xFFFF.
   -> acc_out=0xFFFF0, ovf=0.
4. Max length, default parameters: len=255, all prods 0xFFFF.
   -> acc_out=0xFEFF01, ovf=0.
5. Zero length: start, len=0.
   -> out_valid=1 next cycle with acc_out=0, in_ready never high.
   start pulsed during ACCUM/DONE.
   -> ignored; the run in progress completes with its original len.
6. Reset mid-run: len=5, reset asserted after 2 transfers.
   -> next cycle: in_ready=0, out_valid=0, busy=0, acc_out=0, ovf=0.
   Following run len=1, prod 0x1234.
   -> acc_out=0x001234.

Source files
------------

// File: rtl/prod_accumulator.sv
// Saturating accumulator for a run of unsigned multiplier products.
// Accepts len products over a valid/ready stream, then holds the sum until the consumer takes it.
module prod_accumulator #(
  parameter int unsigned PW = 16,
  parameter int unsigned AW = 24,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] acc_out,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   sum;

  // One extra bit so a carry out of the accumulator is visible as overflow.
  assign sum = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            rem_d   = len;
            state_d = StAccum;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccum: begin
        if (in_valid) begin
          if (sum[AW] || ovf_q) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[AW-1:0];
          end
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench: two accumulators (AW=24 and AW=20) share one stimulus stream.
// Expected sums come from plain arithmetic on the product list, clamped at each width.
module tb_prod_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] prod;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ovf_a, busy_a;
  logic [23:0] acc_a;
  logic        in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [19:0] acc_b;

  prod_accumulator u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .prod      (prod),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .acc_out   (acc_a),
    .ovf       (ovf_a),
    .busy      (busy_a)
  );

  prod_accumulator #(
    .PW (16),
    .AW (20),
    .CW (8)
  ) u_dut20 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .prod      (prod),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .acc_out   (acc_b),
    .ovf       (ovf_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a24;
    logic        o24;
    logic [19:0] a20;
    logic        o20;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] prod_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t model(input longint sum);
    exp_t e;
    longint m24 = 64'hFF_FFFF;
    longint m20 = 64'hF_FFFF;
    e.o24 = (sum > m24);
    e.a24 = e.o24 ? 24'hFF_FFFF : 24'(sum);
    e.o20 = (sum > m20);
    e.a20 = e.o20 ? 20'hF_FFFF : 20'(sum);
    return e;
  endfunction

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid agree", longint'(out_valid_b), longint'(out_valid_a));
      if (out_valid_a) begin
        if (sb_q.size() == 0) begin
          check("unexpected result", 1, 0);
        end else begin
          check("acc_out AW24", longint'(acc_a), longint'(sb_q[0].a24));
          check("ovf AW24", longint'(ovf_a), longint'(sb_q[0].o24));
          check("acc_out AW20", longint'(acc_b), longint'(sb_q[0].a20));
          check("ovf AW20", longint'(ovf_b), longint'(sb_q[0].o20));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic fill_const(input int n, input logic [15:0] v);
    prod_q.delete();
    for (int i = 0; i < n; i++) prod_q.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    prod_q.delete();
    for (int i = 0; i < n; i++) prod_q.push_back(16'($urandom));
  endtask

  // bubble_mode: 0 none, 1 alternate cycles, 2 random. poke drives random start/len mid-run.
  task automatic do_run(input int bubble_mode, input int stall, input bit poke);
    int     n = prod_q.size();
    longint sum = 0;
    int     i = 0;
    int     cyc = 0;
    bit     xfer;
    for (int k = 0; k < n; k++) sum += longint'(prod_q[k]);
    sb_q.push_back(model(sum));
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n == 0) check("zero-len in_ready", longint'(in_ready_a), 0);
    while (i < n) begin
      case (bubble_mode)
        1:       in_valid = cyc[0] ? 1'b0 : 1'b1;
        2:       in_valid = ($urandom_range(99) < 30) ? 1'b0 : 1'b1;
        default: in_valid = 1'b1;
      endcase
      prod = prod_q[i];
      if (poke) begin
        start = 1'($urandom);
        len   = 8'($urandom);
      end
      check("in_ready in run", longint'(in_ready_a), 1);
      check("busy in run", longint'(busy_a), 1);
      xfer = in_valid && in_ready_a;
      @(posedge clk);
      #1;
      if (xfer) i++;
      cyc++;
      if (cyc > 10 * n + 100) begin
        check("run timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
    start    = poke;
    len      = 8'($urandom);
    check("out_valid after last", longint'(out_valid_a), 1);
    check("in_ready in done", longint'(in_ready_a), 0);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check("out_valid held", longint'(out_valid_a), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check("out_valid dropped", longint'(out_valid_a), 0);
    check("busy idle", longint'(busy_a), 0);
  endtask

  task automatic check_reset_state();
    check("rst in_ready", longint'(in_ready_a), 0);
    check("rst out_valid", longint'(out_valid_a), 0);
    check("rst busy", longint'(busy_a), 0);
    check("rst acc_out", longint'(acc_a), 0);
    check("rst ovf", longint'(ovf_a), 0);
    check("rst acc_out AW20", longint'(acc_b), 0);
    check("rst ovf AW20", longint'(ovf_b), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    prod      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    prod_q = '{16'h0001, 16'h00FF, 16'hFFFF};
    do_run(0, 0, 1'b0);
    prod_q = '{16'd5, 16'd6, 16'd7, 16'd8};
    do_run(1, 5, 1'b0);
    fill_const(17, 16'hFFFF);
    do_run(0, 1, 1'b0);
    fill_const(16, 16'hFFFF);
    do_run(0, 0, 1'b0);
    fill_const(255, 16'hFFFF);
    do_run(0, 0, 1'b0);
    prod_q.delete();
    do_run(0, 2, 1'b1);
    fill_rand(6);
    do_run(2, 3, 1'b1);

    // Abandon a run with reset after two transfers.
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b1;
    prod     = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset_state();
    fill_const(1, 16'h1234);
    do_run(0, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      fill_rand(int'($urandom_range(40)));
      do_run(2, int'($urandom_range(3)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", longint'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
